clk_gen_cal_ctrl: RTL and testbench

CLK_GEN_CAL_CTRL -- requirements
Module: clk_gen_cal_ctrl

---
 rtl/clk_gen_cal_pkg.sv | 24 ++
 rtl/clk_gen_edge_counter.sv | 38 +++
 rtl/clk_gen_cal_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_clk_gen_cal_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_cal_pkg.sv
// Shared types and default sizing for the ring-oscillator calibration controller.
package clk_gen_cal_pkg;

    localparam int DEF_CODE_W     = 5;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_WINDOW_CYC = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_DONE    = 3'd4
    } cal_state_e;

    // Phase timer width: must hold 0 .. max(settle, window) - 1.
    function automatic int tmr_width(input int settle_cyc, input int window_cyc);
        int longest;
        longest = (settle_cyc > window_cyc) ? settle_cyc : window_cyc;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/clk_gen_edge_counter.sv
// Rising-edge detector on the synchronized oscillator plus a saturating edge counter.
module clk_gen_edge_counter
    import clk_gen_cal_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] count_o
);

    logic             prev_r;
    logic [CNT_W-1:0] cnt_r;
    logic             edge_s;

    assign edge_s  = sig_i & ~prev_r;
    assign count_o = cnt_r;

    // Clearing loads the current level so a signal already high at window start is not an edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_r <= 1'b0;
            cnt_r  <= '0;
        end else if (clr_i) begin
            prev_r <= sig_i;
            cnt_r  <= '0;
        end else if (en_i) begin
            prev_r <= sig_i;
            if (edge_s && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/clk_gen_cal_ctrl.sv
// Successive-approximation calibration of a ring-oscillator delay code against a target edge count.
// Optional build macro CLK_GEN_CAL_MANUAL_EN adds a manual code override used while idle or done.
module clk_gen_cal_ctrl
    import clk_gen_cal_pkg::*;
#(
    parameter int CODE_W     = DEF_CODE_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int WINDOW_CYC = DEF_WINDOW_CYC
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  target_count_i,
    input  logic              osc_sync_i,
`ifdef CLK_GEN_CAL_MANUAL_EN
    input  logic              manual_en_i,
    input  logic [CODE_W-1:0] manual_code_i,
`endif
    output logic              osc_en_o,
    output logic [CODE_W-1:0] code_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  meas_count_o
);

    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int TMR_W = tmr_width(SETTLE_CYC, WINDOW_CYC);

    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]  WINDOW_LAST = TMR_W'(WINDOW_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_TOP     = IDX_W'(CODE_W - 1);
    localparam logic [CODE_W-1:0] CODE_MSB    = CODE_W'(1) << (CODE_W - 1);

    cal_state_e        state_r, state_next_s;
    logic [CODE_W-1:0] sar_r, sar_next_s;
    logic [IDX_W-1:0]  bit_idx_r, bit_idx_next_s, bit_idx_dec_s;
    logic [CNT_W-1:0]  target_r, target_next_s;
    logic [TMR_W-1:0]  tmr_r, tmr_next_s;
    logic [CNT_W-1:0]  meas_r, meas_next_s;
    logic              cnt_clr_s, cnt_en_s;
    logic [CNT_W-1:0]  cnt_s;

    logic              osc_en_r, osc_en_next_s;
    logic [CODE_W-1:0] code_r, code_next_s;
    logic              busy_r, busy_next_s;
    logic              done_r, done_next_s;

    assign bit_idx_dec_s = bit_idx_r - IDX_W'(1);

    clk_gen_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (cnt_clr_s),
        .en_i    (cnt_en_s),
        .sig_i   (osc_sync_i),
        .count_o (cnt_s)
    );

    // FSM state and search datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= ST_IDLE;
            sar_r     <= '0;
            bit_idx_r <= '0;
            target_r  <= '0;
            tmr_r     <= '0;
            meas_r    <= '0;
        end else begin
            state_r   <= state_next_s;
            sar_r     <= sar_next_s;
            bit_idx_r <= bit_idx_next_s;
            target_r  <= target_next_s;
            tmr_r     <= tmr_next_s;
            meas_r    <= meas_next_s;
        end
    end

    // Next-state and binary-search decisions.
    always_comb begin
        state_next_s   = state_r;
        sar_next_s     = sar_r;
        bit_idx_next_s = bit_idx_r;
        target_next_s  = target_r;
        tmr_next_s     = tmr_r;
        meas_next_s    = meas_r;
        cnt_clr_s      = 1'b0;
        cnt_en_s       = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    target_next_s  = target_count_i;
                    bit_idx_next_s = IDX_TOP;
                    sar_next_s     = CODE_MSB;
                    tmr_next_s     = '0;
                    state_next_s   = ST_SETTLE;
                end else begin
                    state_next_s   = state_r;
                end
            end
            ST_SETTLE: begin
                if (tmr_r == SETTLE_LAST) begin
                    tmr_next_s   = '0;
                    cnt_clr_s    = 1'b1;
                    state_next_s = ST_MEASURE;
                end else begin
                    tmr_next_s   = tmr_r + TMR_W'(1);
                end
            end
            ST_MEASURE: begin
                cnt_en_s = 1'b1;
                if (tmr_r == WINDOW_LAST) begin
                    tmr_next_s   = '0;
                    state_next_s = ST_DECIDE;
                end else begin
                    tmr_next_s   = tmr_r + TMR_W'(1);
                end
            end
            ST_DECIDE: begin
                meas_next_s = cnt_s;
                // Too slow or on target: this delay bit is too long, drop it.
                if (cnt_s > target_r) begin
                    sar_next_s[bit_idx_r] = 1'b1;
                end else begin
                    sar_next_s[bit_idx_r] = 1'b0;
                end
                if (bit_idx_r != '0) begin
                    sar_next_s[bit_idx_dec_s] = 1'b1;
                    bit_idx_next_s            = bit_idx_dec_s;
                    state_next_s              = ST_SETTLE;
                end else begin
                    state_next_s              = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so outputs stay registered.
    always_comb begin
        osc_en_next_s = 1'b0;
        code_next_s   = '0;
        busy_next_s   = 1'b0;
        done_next_s   = 1'b0;

        case (state_next_s)
            ST_SETTLE, ST_MEASURE, ST_DECIDE: begin
                osc_en_next_s = 1'b1;
                code_next_s   = sar_next_s;
                busy_next_s   = 1'b1;
            end
            ST_DONE: begin
                done_next_s   = 1'b1;
                osc_en_next_s = 1'b1;
`ifdef CLK_GEN_CAL_MANUAL_EN
                if (manual_en_i) begin
                    code_next_s = manual_code_i;
                end else begin
                    code_next_s = sar_next_s;
                end
`else
                code_next_s   = sar_next_s;
`endif
            end
            ST_IDLE: begin
`ifdef CLK_GEN_CAL_MANUAL_EN
                if (manual_en_i) begin
                    osc_en_next_s = 1'b1;
                    code_next_s   = manual_code_i;
                end else begin
                    osc_en_next_s = 1'b0;
                    code_next_s   = '0;
                end
`else
                osc_en_next_s = 1'b0;
                code_next_s   = '0;
`endif
            end
            default: begin
                osc_en_next_s = 1'b0;
                code_next_s   = '0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            osc_en_r <= 1'b0;
            code_r   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            osc_en_r <= osc_en_next_s;
            code_r   <= code_next_s;
            busy_r   <= busy_next_s;
            done_r   <= done_next_s;
        end
    end

    assign osc_en_o     = osc_en_r;
    assign code_o       = code_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign meas_count_o = meas_r;

endmodule

// File: tb/tb_clk_gen_cal_ctrl.sv
// Self-checking bench for clk_gen_cal_ctrl: table vectors, randomized count tables, and corner sequences.
module tb_clk_gen_cal_ctrl;

    localparam int ROUND   = 4 + 64 + 1;   // settle + window + decide
    localparam int LATENCY = 5 * ROUND;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] target;
    logic        osc;
    logic        osc_en;
    logic [4:0]  code;
    logic        busy;
    logic        done;
    logic [15:0] meas;

    logic        start2;
    logic [3:0]  target2;
    logic        osc2;
    logic        osc_en2;
    logic [4:0]  code2;
    logic        busy2;
    logic        done2;
    logic [3:0]  meas2;

`ifdef CLK_GEN_CAL_MANUAL_EN
    logic        manual_en;
    logic [4:0]  manual_code;
    logic        manual_en2;
    logic [4:0]  manual_code2;
`endif

    int errors = 0;
    int checks = 0;

    int cnt_tab [32];
    int exp_trials [5];
    int exp_code;
    int exp_meas;

    always #5 clk = ~clk;

    clk_gen_cal_ctrl dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .target_count_i (target),
        .osc_sync_i     (osc),
`ifdef CLK_GEN_CAL_MANUAL_EN
        .manual_en_i    (manual_en),
        .manual_code_i  (manual_code),
`endif
        .osc_en_o       (osc_en),
        .code_o         (code),
        .busy_o         (busy),
        .done_o         (done),
        .meas_count_o   (meas)
    );

    clk_gen_cal_ctrl #(.CNT_W(4)) dut_sat (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start2),
        .target_count_i (target2),
        .osc_sync_i     (osc2),
`ifdef CLK_GEN_CAL_MANUAL_EN
        .manual_en_i    (manual_en2),
        .manual_code_i  (manual_code2),
`endif
        .osc_en_o       (osc_en2),
        .code_o         (code2),
        .busy_o         (busy2),
        .done_o         (done2),
        .meas_count_o   (meas2)
    );

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Oscillator behaviour: edges per window as a function of the code.
    // kind 0: 32 - code (monotone; the 100-3*code law exceeds the 32-edge ceiling of a 64-cycle window)
    // kind 1: oscillator stuck low; kind 2: random table.
    function automatic int osc_count(input int kind, input int c);
        case (kind)
            0:       return 32 - c;
            1:       return 0;
            2:       return cnt_tab[c];
            default: return 0;
        endcase
    endfunction

    // Reference: plain successive approximation, MSB first, keep bit when count > target.
    task automatic model_search(input int kind, input int tgt);
        int c;
        int trial;
        int m;
        c = 0;
        m = 0;
        for (int b = 4; b >= 0; b--) begin
            trial = c | (1 << b);
            exp_trials[4 - b] = trial;
            m = osc_count(kind, trial);
            if (m > tgt) c = trial;
        end
        exp_code = c;
        exp_meas = m;
    endtask

    // One calibration; optional stray start at cycle 100 or reset at cycle 150.
    task automatic run_cal(input string tag, input int kind, input int tgt,
                           input int exp_c, input int exp_m,
                           input bit restart_at_100, input bit reset_at_150);
        int done_cyc;
        int p;
        int r;
        int n;
        model_search(kind, tgt);
        @(negedge clk);
        target = 16'(tgt);
        start  = 1'b1;
        osc    = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        done_cyc = -1;
        for (int k = 1; k <= LATENCY + 50 && done_cyc < 0; k++) begin
            p = k % ROUND;
            r = k / ROUND;
            n = (r < 5) ? osc_count(kind, exp_trials[r]) : 0;
            osc = (p >= 5) && (p <= 67) && (((p - 5) % 2) == 0) && (((p - 5) / 2) < n);
            start = restart_at_100 && (k == 100);
            if (start) target = 16'(tgt + 7);
            @(negedge clk);
            if (reset_at_150 && k == 150) begin
                reset = 1'b1;
                #1;
                chk({tag, " rst osc_en"}, osc_en, 0);
                chk({tag, " rst code"},   code,   0);
                chk({tag, " rst busy"},   busy,   0);
                chk({tag, " rst done"},   done,   0);
                chk({tag, " rst meas"},   meas,   0);
                @(negedge clk);
                reset = 1'b0;
                osc   = 1'b0;
                start = 1'b0;
                return;
            end
            if (p == 1 && r < 5) begin
                chk($sformatf("%s trial%0d code", tag, r), code, exp_trials[r]);
                chk($sformatf("%s trial%0d busy", tag, r), busy, 1);
            end
            if (done) done_cyc = k;
        end
        start = 1'b0;
        osc   = 1'b0;
        chk({tag, " latency"}, done_cyc, LATENCY);
        chk({tag, " code"},    code,     exp_c);
        chk({tag, " meas"},    meas,     exp_m);
        chk({tag, " busy"},    busy,     0);
        chk({tag, " osc_en"},  osc_en,   1);
    endtask

    // Saturation on the 4-bit counter instance: oscillator toggles every cycle.
    task automatic run_sat();
        int done_cyc;
        bit wrapped;
        @(negedge clk);
        target2 = 4'd14;
        start2  = 1'b1;
        @(negedge clk);
        start2  = 1'b0;
        done_cyc = -1;
        wrapped  = 1'b0;
        for (int k = 1; k <= LATENCY + 50 && done_cyc < 0; k++) begin
            osc2 = ~osc2;
            @(negedge clk);
            if (meas2 != 4'd0 && meas2 != 4'd15) wrapped = 1'b1;
            if (done2) done_cyc = k;
        end
        chk("sat no_wrap", wrapped, 0);
        chk("sat latency", done_cyc, LATENCY);
        chk("sat meas",    meas2, 15);
        chk("sat code",    code2, 31);
    endtask

    typedef struct {
        string name;
        int    kind;
        int    tgt;
        int    exp_c;
        int    exp_m;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{name: "vec_search",   kind: 0, tgt: 22, exp_c: 9,  exp_m: 23};
        vecs[1] = '{name: "vec_stuck_lo", kind: 1, tgt: 0,  exp_c: 0,  exp_m: 0};
        vecs[2] = '{name: "vec_all_clr",  kind: 0, tgt: 40, exp_c: 0,  exp_m: 31};
        vecs[3] = '{name: "vec_all_set",  kind: 0, tgt: 0,  exp_c: 31, exp_m: 1};

        reset   = 1'b1;
        start   = 1'b0;
        target  = 16'd0;
        osc     = 1'b0;
        start2  = 1'b0;
        target2 = 4'd0;
        osc2    = 1'b0;
`ifdef CLK_GEN_CAL_MANUAL_EN
        manual_en    = 1'b0;
        manual_code  = 5'd0;
        manual_en2   = 1'b0;
        manual_code2 = 5'd0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("reset osc_en", osc_en, 0);
        chk("reset code",   code,   0);
        chk("reset busy",   busy,   0);
        chk("reset done",   done,   0);
        chk("reset meas",   meas,   0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle osc_en", osc_en, 0);

`ifdef CLK_GEN_CAL_MANUAL_EN
        manual_en   = 1'b1;
        manual_code = 5'd7;
        @(negedge clk);
        @(negedge clk);
        chk("manual code",   code,   7);
        chk("manual osc_en", osc_en, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("manual start code", code, 16);
        chk("manual start busy", busy, 1);
        manual_en = 1'b0;
        for (int k = 0; k < LATENCY + 50 && !done; k++) @(negedge clk);
        chk("manual run done", done, 1);
`endif

        for (int i = 0; i < 4; i++) begin
            run_cal(vecs[i].name, vecs[i].kind, vecs[i].tgt, vecs[i].exp_c, vecs[i].exp_m, 1'b0, 1'b0);
        end

        run_cal("restart_ignored", 0, 22, 9, 23, 1'b1, 1'b0);
        run_cal("mid_reset", 0, 22, 9, 23, 1'b0, 1'b1);
        chk("post_reset done", done, 0);
        run_cal("after_reset", 0, 22, 9, 23, 1'b0, 1'b0);

        run_sat();

        for (int it = 0; it < 12; it++) begin
            int tgt;
            for (int c = 0; c < 32; c++) cnt_tab[c] = int'($urandom_range(0, 32));
            tgt = int'($urandom_range(0, 33));
            model_search(2, tgt);
            run_cal($sformatf("rand%0d", it), 2, tgt, exp_code, exp_meas, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
